incr_share_arb: RTL and testbench

- Shares one W-bit incrementer datapath among N requesters.
- Round-robin arbiter picks one valid request per cycle and increments its operand.
- Result is returned through a single registered response channel with valid/ready backpressure, tagged with the requester index and a wrap (overflow) flag.
- Sits between multiple counter/pointer-owning clients and the shared increment datapath. Increment is modulo 2^W.

---
 rtl/incr_share_arb.sv | 152 +++++++++++++++
 tb/tb_incr_share_arb.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/incr_share_arb.sv
// incr_share_arb
//   Shares one W-bit incrementer among N requesters. A round-robin arbiter
//   picks at most one valid request per cycle. It computes x+1 mod 2^W and
//   holds the result in a single response register. The response is tagged
//   with the requester index and a wrap flag.
//
// Ports
//   clk      : clock, all state updates on the rising edge
//   rst      : synchronous, active-high reset
//   req_vld  : [N]   per-requester request valid
//   req_x    : [N*W] per-requester operand, requester i at bits [i*W +: W]
//   req_rdy  : [N]   per-requester accept strobe (one-hot or zero, combinational)
//   rsp_vld  : response valid
//   rsp_y    : [W]   incremented operand
//   rsp_id   : [$clog2(N)] index of the requester that produced rsp_y
//   rsp_ovf  : operand was all-ones and the result wrapped to zero
//   rsp_rdy  : response consumer ready
module incr_share_arb #(
    parameter  int N  = 4,
    parameter  int W  = 32,
    localparam int IW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_vld,
    input  logic [N*W-1:0] req_x,
    output logic [N-1:0]   req_rdy,
    output logic           rsp_vld,
    output logic [W-1:0]   rsp_y,
    output logic [IW-1:0]  rsp_id,
    output logic           rsp_ovf,
    input  logic           rsp_rdy
);

    logic          rsp_vld_q, rsp_vld_d;
    logic [W-1:0]  rsp_y_q,   rsp_y_d;
    logic [IW-1:0] rsp_id_q,  rsp_id_d;
    logic          rsp_ovf_q, rsp_ovf_d;
    logic [IW-1:0] ptr_q,     ptr_d;

    logic          free;
    logic          any_req;
    logic          accept;
    logic          found;
    int            cand;
    logic [IW-1:0] gnt_idx;
    logic [N-1:0]  gnt_oh;
    logic [IW-1:0] ptr_nxt;

    logic [W-1:0]  op_x;
    logic [W-1:0]  inc_mask;
    logic [W-1:0]  inc_y;
    logic          inc_ovf;
    logic          carry;

    // The response slot can take a new result when it is empty or being drained.
    assign free    = ~rsp_vld_q | rsp_rdy;
    assign any_req = |req_vld;
    assign accept  = free & any_req & ~rst;

    // Cyclic search starting at ptr_q. The first hit wins.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && req_vld[cand]) begin
                found   = 1'b1;
                gnt_idx = IW'(cand);
            end
        end
    end

    always_comb begin
        gnt_oh          = '0;
        gnt_oh[gnt_idx] = 1'b1;
    end

    assign req_rdy = accept ? gnt_oh : '0;

    assign ptr_nxt = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;

    assign op_x = req_x[gnt_idx*W +: W];

    // Incrementer built as find-first-zero. Every bit up to and including the
    // lowest zero flips. A carry out of the top bit means the operand was
    // all-ones, so the result wraps to zero.
    always_comb begin
        carry    = 1'b1;
        inc_mask = '0;
        for (int b = 0; b < W; b++) begin
            inc_mask[b] = carry;
            carry       = carry & op_x[b];
        end
    end

    assign inc_y   = op_x ^ inc_mask;
    assign inc_ovf = carry;

    always_comb begin
        rsp_vld_d = rsp_vld_q;
        rsp_y_d   = rsp_y_q;
        rsp_id_d  = rsp_id_q;
        rsp_ovf_d = rsp_ovf_q;
        ptr_d     = ptr_q;
        if (accept) begin
            // A drain and a refill can happen in the same cycle, so there is no bubble.
            rsp_vld_d = 1'b1;
            rsp_y_d   = inc_y;
            rsp_id_d  = gnt_idx;
            rsp_ovf_d = inc_ovf;
            ptr_d     = ptr_nxt;
        end else if (rsp_vld_q && rsp_rdy) begin
            rsp_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_vld_q <= 1'b0;
            rsp_y_q   <= '0;
            rsp_id_q  <= '0;
            rsp_ovf_q <= 1'b0;
            ptr_q     <= '0;
        end else begin
            rsp_vld_q <= rsp_vld_d;
            rsp_y_q   <= rsp_y_d;
            rsp_id_q  <= rsp_id_d;
            rsp_ovf_q <= rsp_ovf_d;
            ptr_q     <= ptr_d;
        end
    end

    assign rsp_vld = rsp_vld_q;
    assign rsp_y   = rsp_y_q;
    assign rsp_id  = rsp_id_q;
    assign rsp_ovf = rsp_ovf_q;

    a_rdy_onehot0 : assert property (@(posedge clk) disable iff (rst)
        $onehot0(req_rdy));

    a_rdy_implies_vld : assert property (@(posedge clk) disable iff (rst)
        (req_rdy & ~req_vld) == '0);

    a_rsp_stable : assert property (@(posedge clk) disable iff (rst)
        (rsp_vld && !rsp_rdy) |=> (rsp_vld && $stable(rsp_y) && $stable(rsp_id) && $stable(rsp_ovf)));

endmodule

// File: tb/tb_incr_share_arb.sv
// Self-checking bench for incr_share_arb.
// The driver applies inputs on the falling edge. A reference model tracks the
// round-robin pointer and the occupancy of the response slot. Each accepted
// request pushes its expected response into a queue. A separate monitor pops
// that queue on every response handshake and compares the fields.
module tb_incr_share_arb;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_vld = '0;
    logic [N*W-1:0] req_x = '0;
    logic [N-1:0]   req_rdy;
    logic           rsp_vld;
    logic [W-1:0]   rsp_y;
    logic [IW-1:0]  rsp_id;
    logic           rsp_ovf;
    logic           rsp_rdy = 1'b0;

    incr_share_arb #(.N(N), .W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_vld (req_vld),
        .req_x   (req_x),
        .req_rdy (req_rdy),
        .rsp_vld (rsp_vld),
        .rsp_y   (rsp_y),
        .rsp_id  (rsp_id),
        .rsp_ovf (rsp_ovf),
        .rsp_rdy (rsp_rdy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [W-1:0]  y;
        logic          ovf;
    } rsp_t;

    rsp_t         exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    bit           pend[N];
    logic [W-1:0] px[N];
    int           m_ptr = 0;
    bit           m_vld = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // A requester holds its request until it is granted.
    task automatic set_req(input int i, input logic [W-1:0] x);
        if (!pend[i]) begin
            pend[i] = 1'b1;
            px[i]   = x;
        end
    endtask

    function automatic logic [W-1:0] rand_x();
        case ($urandom % 8)
            0:       return '1;
            1:       return 32'h7FFF_FFFF;
            2:       return '0;
            default: return $urandom;
        endcase
    endfunction

    // One clock cycle. gnt reports the index the DUT granted, or -1 if it
    // granted none.
    task automatic step(input bit rdy, input bit rst_in, output int gnt);
        int           mg;
        bit           acc;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        rst     = rst_in;
        rsp_rdy = rdy;
        for (int i = 0; i < N; i++) begin
            req_vld[i]       = pend[i];
            req_x[i*W +: W]  = px[i];
        end
        #1;
        mg = -1;
        for (int k = 0; k < N; k++) begin
            if (mg < 0 && pend[(m_ptr + k) % N]) mg = (m_ptr + k) % N;
        end
        acc     = !rst_in && (!m_vld || rdy) && (mg >= 0);
        exp_rdy = '0;
        if (acc) exp_rdy[mg] = 1'b1;
        chk("req_rdy", 64'(req_rdy), 64'(exp_rdy));
        chk("rsp_vld", 64'(rsp_vld), 64'(m_vld));
        gnt = -1;
        for (int i = 0; i < N; i++) begin
            if (gnt < 0 && req_rdy[i]) gnt = i;
        end
        if (rst_in) begin
            m_vld = 1'b0;
            m_ptr = 0;
            exp_q.delete();
        end else if (acc) begin
            exp_q.push_back(rsp_t'{id: IW'(mg), y: W'(px[mg] + 1'b1), ovf: (px[mg] == '1)});
            m_ptr = (mg + 1) % N;
            m_vld = 1'b1;
        end else if (m_vld && rdy) begin
            m_vld = 1'b0;
        end
        @(posedge clk);
        if (gnt >= 0) pend[gnt] = 1'b0;
    endtask

    // Monitor: checks the response on every handshake and checks that the
    // response holds across stall cycles.
    rsp_t prev;
    bit   prev_stall = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_hold", 64'({rsp_vld, rsp_id, rsp_y, rsp_ovf}), 64'({1'b1, prev}));
                end
                if (rsp_vld && rsp_rdy) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL rsp_unexpected: got id %0d y 0x%0h, expected no response", rsp_id, rsp_y);
                    end else begin
                        rsp_t e;
                        e = exp_q.pop_front();
                        chk("rsp_id",  64'(rsp_id),  64'(e.id));
                        chk("rsp_y",   64'(rsp_y),   64'(e.y));
                        chk("rsp_ovf", 64'(rsp_ovf), 64'(e.ovf));
                    end
                end
                prev_stall = rsp_vld && !rsp_rdy;
                prev       = rsp_t'{id: rsp_id, y: rsp_y, ovf: rsp_ovf};
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int rr_tail[6] = '{2, 3, 0, 2, 3, 0};
        int guard;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            px[i]   = '0;
        end
        repeat (2) @(posedge clk);

        // Reset state
        step(0, 1, g);
        chk("rst_gnt", 64'(g), 64'(-1));
        #1;
        chk("rst_vld", 64'(rsp_vld), 64'd0);
        chk("rst_y",   64'(rsp_y),   64'd0);
        chk("rst_id",  64'(rsp_id),  64'd0);
        chk("rst_ovf", 64'(rsp_ovf), 64'd0);

        // Single request
        set_req(0, 32'h0000_0005);
        step(1, 0, g);
        chk("single_gnt", 64'(g), 64'd0);
        #1;
        chk("single_vld", 64'(rsp_vld), 64'd1);
        chk("single_y",   64'(rsp_y),   64'h6);
        chk("single_id",  64'(rsp_id),  64'd0);
        chk("single_ovf", 64'(rsp_ovf), 64'd0);

        // Wrap and near-wrap operands
        set_req(2, 32'hFFFF_FFFF);
        step(1, 0, g);
        chk("wrap_gnt", 64'(g), 64'd2);
        #1;
        chk("wrap_y",   64'(rsp_y),   64'h0);
        chk("wrap_ovf", 64'(rsp_ovf), 64'd1);
        chk("wrap_id",  64'(rsp_id),  64'd2);
        set_req(1, 32'h7FFF_FFFF);
        step(1, 0, g);
        chk("half_gnt", 64'(g), 64'd1);
        #1;
        chk("half_y",   64'(rsp_y),   64'h8000_0000);
        chk("half_ovf", 64'(rsp_ovf), 64'd0);

        // Idle pointer hold: grant 3, idle, then 0 and 3 compete
        set_req(3, 32'h0000_0010);
        step(1, 0, g);
        chk("idle_gnt3", 64'(g), 64'd3);
        repeat (5) step(1, 0, g);
        set_req(0, 32'h0000_0020);
        set_req(3, 32'h0000_0030);
        step(1, 0, g);
        chk("idle_gnt0", 64'(g), 64'd0);
        step(1, 0, g);
        chk("idle_gnt3b", 64'(g), 64'd3);

        // Round-robin with all four requesters continuously valid
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < N; i++) set_req(i, $urandom);
            step(1, 0, g);
            chk("rr_gnt", 64'(g), 64'(k % N));
            #1;
            chk("rr_nobubble", 64'(rsp_vld), 64'd1);
        end
        // Requester 1 stops requesting
        for (int k = 0; k < 6; k++) begin
            set_req(0, $urandom);
            set_req(2, $urandom);
            set_req(3, $urandom);
            step(1, 0, g);
            chk("rr_skip1", 64'(g), 64'(rr_tail[k]));
        end

        // Backpressure with all requesters pending
        for (int i = 0; i < N; i++) set_req(i, rand_x());
        for (int k = 0; k < 3; k++) begin
            step(0, 0, g);
            chk("bp_no_gnt", 64'(g), 64'(-1));
        end
        step(1, 0, g);
        chk("bp_release_gnt", 64'(g), 64'd1);
        #1;
        chk("bp_new_id", 64'(rsp_id), 64'd1);
        step(1, 0, g);
        chk("bp_next_gnt", 64'(g), 64'd2);

        // Reset mid-stream with a response pending and every requester valid
        for (int i = 0; i < N; i++) set_req(i, rand_x());
        step(0, 1, g);
        chk("mid_rst_gnt", 64'(g), 64'(-1));
        #1;
        chk("mid_rst_vld", 64'(rsp_vld), 64'd0);
        chk("mid_rst_y",   64'(rsp_y),   64'd0);
        chk("mid_rst_id",  64'(rsp_id),  64'd0);
        chk("mid_rst_ovf", 64'(rsp_ovf), 64'd0);
        step(1, 0, g);
        chk("post_rst_gnt", 64'(g), 64'd0);

        // Random traffic with random backpressure and occasional reset
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom % 4 == 0)) set_req(i, rand_x());
            end
            step(($urandom % 10) < 7, ($urandom % 400) == 0, g);
        end

        // Drain any remaining work
        guard = 0;
        while ((exp_q.size() != 0 || m_vld || pend[0] || pend[1] || pend[2] || pend[3]) && guard < 50) begin
            step(1, 0, g);
            guard++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_vld",   64'(m_vld),        64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
